// File: rtl/exc_controller.sv
// Exception/interrupt sequencer for the single-cycle LEGv8 core: arbitrates invalid-opcode
// and IRQ events, saves ELR/ESR and steers PC entry to and return from the handler.
module exc_controller #(
    parameter int unsigned     N           = 64,
    parameter logic [N-1:0]    VECTOR_ADDR = N'(64'h0000_0000_0000_00D8),
    parameter int unsigned     CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ExtIRQ,
    output logic             ExtIAck,
    input  logic             NotAnInstr,
    input  logic             ERet,
    input  logic [3:0]       EStatus,
    input  logic [N-1:0]     PC,
    output logic             Squash,
    output logic             Exc,
    output logic [N-1:0]     ExcVector,
    output logic             ERetTaken,
    output logic [N-1:0]     ELR,
    output logic [N-1:0]     ESR,
    output logic             InHandler,
    output logic             DoubleFault,
    output logic [CNT_W-1:0] ExcCount
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_HANDLER = 3'd2,
        S_RETURN  = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_irq_pend;
    logic               w_irq_pend_nxt;
    logic               w_irq;
    logic               w_squash;
    logic               w_capture;
    logic               w_take_irq;
    logic               w_fault;
    logic               r_exc;
    logic               r_eret_taken;
    logic               r_in_handler;
    logic               r_ack;
    logic               r_double_fault;
    logic [N-1:0]       r_elr;
    logic [N-1:0]       r_esr;
    logic [CNT_W-1:0]   r_cnt;

    // A pending (masked-in-handler) IRQ counts as a live request once back in IDLE.
    assign w_irq = ExtIRQ | r_irq_pend;

    // Next-state, squash and capture decisions.
    always_comb begin
        w_next         = r_state;
        w_irq_pend_nxt = r_irq_pend;
        w_squash       = 1'b0;
        w_capture      = 1'b0;
        w_take_irq     = 1'b0;
        w_fault        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (NotAnInstr || w_irq) begin
                    w_squash  = 1'b1;
                    w_capture = 1'b1;
                    w_next    = S_ENTRY;
                    if (NotAnInstr) begin
                        // Invalid opcode wins; a simultaneous IRQ is deferred until after return.
                        if (w_irq) w_irq_pend_nxt = 1'b1;
                    end else begin
                        w_take_irq     = 1'b1;
                        w_irq_pend_nxt = 1'b0;
                    end
                end
            end
            S_ENTRY: begin
                w_squash = 1'b1;
                w_next   = S_HANDLER;
            end
            S_HANDLER: begin
                if (ExtIRQ) w_irq_pend_nxt = 1'b1;
                if (NotAnInstr) begin
                    w_squash = 1'b1;
                    w_fault  = 1'b1;
                    w_next   = S_HALT;
                end else if (ERet) begin
                    w_next = S_RETURN;
                end
            end
            S_RETURN: begin
                w_squash = 1'b1;
                w_next   = S_IDLE;
            end
            S_HALT: begin
                w_squash = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs are derived from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_irq_pend     <= 1'b0;
            r_exc          <= 1'b0;
            r_eret_taken   <= 1'b0;
            r_in_handler   <= 1'b0;
            r_ack          <= 1'b0;
            r_double_fault <= 1'b0;
            r_elr          <= '0;
            r_esr          <= '0;
            r_cnt          <= '0;
        end else begin
            r_state      <= w_next;
            r_irq_pend   <= w_irq_pend_nxt;
            r_exc        <= (w_next == S_ENTRY);
            r_eret_taken <= (w_next == S_RETURN);
            r_in_handler <= (w_next == S_HANDLER);
            r_ack        <= w_take_irq;
            if (w_fault) r_double_fault <= 1'b1;
            if (w_capture) begin
                r_elr <= PC;
                r_esr <= w_take_irq ? N'(1) : N'(EStatus);
            end
            if ((w_next == S_ENTRY) && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign Squash      = w_squash;
    assign Exc         = r_exc;
    assign ExcVector   = VECTOR_ADDR;
    assign ERetTaken   = r_eret_taken;
    assign ELR         = r_elr;
    assign ESR         = r_esr;
    assign InHandler   = r_in_handler;
    assign DoubleFault = r_double_fault;
    assign ExtIAck     = r_ack;
    assign ExcCount    = r_cnt;

endmodule

// File: tb/tb_exc_controller.sv
// Directed scoreboard bench for exc_controller: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_exc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        ExtIRQ;
    logic        ExtIAck;
    logic        NotAnInstr;
    logic        ERet;
    logic [3:0]  EStatus;
    logic [63:0] PC;
    logic        Squash;
    logic        Exc;
    logic [63:0] ExcVector;
    logic        ERetTaken;
    logic [63:0] ELR;
    logic [63:0] ESR;
    logic        InHandler;
    logic        DoubleFault;
    logic [7:0]  ExcCount;

    exc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .ExtIRQ     (ExtIRQ),
        .ExtIAck    (ExtIAck),
        .NotAnInstr (NotAnInstr),
        .ERet       (ERet),
        .EStatus    (EStatus),
        .PC         (PC),
        .Squash     (Squash),
        .Exc        (Exc),
        .ExcVector  (ExcVector),
        .ERetTaken  (ERetTaken),
        .ELR        (ELR),
        .ESR        (ESR),
        .InHandler  (InHandler),
        .DoubleFault(DoubleFault),
        .ExcCount   (ExcCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sq, exc, ert, ack, inh, df;
        logic [63:0] elr, esr;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          n_cmp  = 0;
    int          n_miss = 0;
    logic [63:0] e_elr  = '0;
    logic [63:0] e_esr  = '0;
    logic [7:0]  e_cnt  = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show during that cycle.
    task automatic cyc(input logic rst, input logic irq, input logic nai, input logic eret,
                       input logic [3:0] es, input logic [63:0] pc,
                       input logic sq, input logic exc, input logic ert,
                       input logic ack, input logic inh, input logic df);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; ExtIRQ = irq; NotAnInstr = nai; ERet = eret; EStatus = es; PC = pc;
        e.sq = sq; e.exc = exc; e.ert = ert; e.ack = ack; e.inh = inh; e.df = df;
        e.elr = e_elr; e.esr = e_esr; e.cnt = e_cnt;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            m_e = q.pop_front();
            chk("Squash",      64'(Squash),      64'(m_e.sq));
            chk("Exc",         64'(Exc),         64'(m_e.exc));
            chk("ERetTaken",   64'(ERetTaken),   64'(m_e.ert));
            chk("ExtIAck",     64'(ExtIAck),     64'(m_e.ack));
            chk("InHandler",   64'(InHandler),   64'(m_e.inh));
            chk("DoubleFault", 64'(DoubleFault), 64'(m_e.df));
            chk("ELR",         ELR,              m_e.elr);
            chk("ESR",         ESR,              m_e.esr);
            chk("ExcCount",    64'(ExcCount),    64'(m_e.cnt));
            chk("ExcVector",   ExcVector,        64'h0000_0000_0000_00D8);
        end
    end

    initial begin
        reset = 1'b1; ExtIRQ = 1'b0; NotAnInstr = 1'b0; ERet = 1'b0; EStatus = 4'd0; PC = '0;

        // Reset state
        cyc(0,0,0,0,0,64'h0, 0,0,0,0,0,0);
        cyc(0,0,0,0,0,64'h4, 0,0,0,0,0,0);

        // Invalid opcode at 0x40
        cyc(0,0,1,0,2,64'h40, 1,0,0,0,0,0);
        e_elr = 64'h40; e_esr = 64'h2; e_cnt = 8'd1;
        cyc(0,0,0,0,0,64'h44, 1,1,0,0,0,0);
        cyc(0,0,0,0,0,64'hD8, 0,0,0,0,1,0);
        cyc(0,0,0,1,0,64'hDC, 0,0,0,0,1,0);
        cyc(0,0,0,0,0,64'hE0, 1,0,1,0,0,0);
        cyc(0,0,0,0,0,64'h44, 0,0,0,0,0,0);

        // IRQ pulse at 0x80
        cyc(0,1,0,0,0,64'h80, 1,0,0,0,0,0);
        e_elr = 64'h80; e_esr = 64'h1; e_cnt = 8'd2;
        cyc(0,0,0,0,0,64'h84, 1,1,0,1,0,0);
        cyc(0,0,0,0,0,64'hD8, 0,0,0,0,1,0);
        cyc(0,0,0,1,0,64'hDC, 0,0,0,0,1,0);
        cyc(0,0,0,0,0,64'hE0, 1,0,1,0,0,0);
        cyc(0,0,0,0,0,64'h84, 0,0,0,0,0,0);

        // Invalid opcode and IRQ together: opcode first, IRQ after the return
        cyc(0,1,1,0,2,64'h100, 1,0,0,0,0,0);
        e_elr = 64'h100; e_esr = 64'h2; e_cnt = 8'd3;
        cyc(0,0,0,0,0,64'h104, 1,1,0,0,0,0);
        cyc(0,0,0,0,0,64'hD8,  0,0,0,0,1,0);
        cyc(0,0,0,1,0,64'hDC,  0,0,0,0,1,0);
        cyc(0,0,0,0,0,64'hE0,  1,0,1,0,0,0);
        cyc(0,0,0,0,0,64'h200, 1,0,0,0,0,0);
        e_elr = 64'h200; e_esr = 64'h1; e_cnt = 8'd4;
        cyc(0,0,0,0,0,64'h204, 1,1,0,1,0,0);
        cyc(0,0,0,1,0,64'hD8,  0,0,0,0,1,0);
        cyc(0,0,0,0,0,64'hDC,  1,0,1,0,0,0);
        cyc(0,0,0,0,0,64'h204, 0,0,0,0,0,0);

        // IRQ while in the handler is held pending
        cyc(0,0,1,0,2,64'h300, 1,0,0,0,0,0);
        e_elr = 64'h300; e_esr = 64'h2; e_cnt = 8'd5;
        cyc(0,0,0,0,0,64'h304, 1,1,0,0,0,0);
        cyc(0,1,0,0,0,64'hD8,  0,0,0,0,1,0);
        cyc(0,0,0,1,0,64'hDC,  0,0,0,0,1,0);
        cyc(0,0,0,0,0,64'hE0,  1,0,1,0,0,0);
        cyc(0,0,0,0,0,64'h340, 1,0,0,0,0,0);
        e_elr = 64'h340; e_esr = 64'h1; e_cnt = 8'd6;
        cyc(0,0,0,0,0,64'h344, 1,1,0,1,0,0);
        cyc(0,0,0,1,0,64'hD8,  0,0,0,0,1,0);
        cyc(0,0,0,0,0,64'hDC,  1,0,1,0,0,0);
        cyc(0,0,0,0,0,64'h344, 0,0,0,0,0,0);

        // Spurious ERET in IDLE
        cyc(0,0,0,1,0,64'h400, 0,0,0,0,0,0);
        cyc(0,0,0,0,0,64'h404, 0,0,0,0,0,0);

        // Double fault, then HALT until reset
        cyc(0,0,1,0,2,64'h500, 1,0,0,0,0,0);
        e_elr = 64'h500; e_esr = 64'h2; e_cnt = 8'd7;
        cyc(0,0,0,0,0,64'h504, 1,1,0,0,0,0);
        cyc(0,0,1,0,3,64'hD8,  1,0,0,0,1,0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1'(i % 3 == 0), 1'(i % 4 == 1), 1'(i % 2 == 0), 4'd2, 64'h600 + 64'(i),
                1,0,0,0,0,1);
        end
        cyc(1,0,0,0,0,64'h0, 1,0,0,0,0,1);
        e_elr = '0; e_esr = '0; e_cnt = '0;
        cyc(0,0,0,0,0,64'h0, 0,0,0,0,0,0);

        // 260 exceptions: counter saturates at 255
        for (int i = 0; i < 260; i++) begin
            cyc(0,0,1,0,2,64'(i * 4), 1,0,0,0,0,0);
            e_elr = 64'(i * 4); e_esr = 64'h2;
            e_cnt = (e_cnt == 8'hFF) ? 8'hFF : e_cnt + 8'd1;
            cyc(0,0,0,0,0,64'h1000, 1,1,0,0,0,0);
            cyc(0,0,0,1,0,64'hD8,   0,0,0,0,1,0);
            cyc(0,0,0,0,0,64'hDC,   1,0,1,0,0,0);
        end
        cyc(0,0,0,0,0,64'h2000, 0,0,0,0,0,0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
